// File: rtl/par2ser_pkg.sv
// par2ser_pkg: shared FSM state encoding and default sizing for the par2ser serializer.
package par2ser_pkg;

    localparam int DefBitLen = 8;
    localparam int DefGapLen = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } par2ser_state_e;

endpackage

// File: rtl/par2ser_buf.sv
// par2ser_buf: one-word holding register with full flag, used when PAR2SER_BUF_EN is defined.
module par2ser_buf
    import par2ser_pkg::*;
#(
    parameter int bitlen = DefBitLen
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Wr,
    input  logic [bitlen-1:0] WrData,
    input  logic              Clr,
    output logic [bitlen-1:0] RdData,
    output logic              Full
);

    // Holding register: a write fills it, a drain empties it, reset discards it.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Full   <= 1'b0;
            RdData <= '0;
        end else if (Wr) begin
            Full   <= 1'b1;
            RdData <= WrData;
        end else if (Clr) begin
            Full   <= 1'b0;
        end else begin
            Full   <= Full;
        end
    end

endmodule

// File: rtl/par2ser.sv
// par2ser: parallel-to-serial converter, LSB first, with idle gap between words.
// Optional one-word holding buffer for back-to-back words: define PAR2SER_BUF_EN.
module par2ser
    import par2ser_pkg::*;
#(
    parameter int bitlen = DefBitLen,
    parameter int gaplen = DefGapLen
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [bitlen-1:0] ParDataIn,
    input  logic              ParDataValid,
    output logic              ParDataReady,
    output logic              SerDataOut,
    output logic              SerDataEn,
    output logic              Busy
);

    localparam int BitW = $clog2(bitlen);
    localparam int GapW = (gaplen > 0) ? $clog2(gaplen + 1) : 1;
    localparam logic [BitW-1:0] BitLast = BitW'(bitlen - 1);
    localparam logic [GapW-1:0] GapLast = GapW'(gaplen - 1);

    par2ser_state_e    state;
    logic [bitlen-1:0] shReg;
    logic [BitW-1:0]   bitCnt;
    logic [GapW-1:0]   gapCnt;
    logic              xfer;
    logic              decide;
    logic              loadNext;
    logic [bitlen-1:0] nextData;
    logic              bufFull;
    logic [bitlen-1:0] bufData;

    assign xfer = ParDataValid && ParDataReady;

`ifdef PAR2SER_BUF_EN
    logic bufWr;
    logic bufClr;

    // A word arriving at the decision point goes straight to the shifter instead.
    assign bufWr  = xfer && (state != IDLE) && !decide;
    assign bufClr = decide && bufFull;

    par2ser_buf #(
        .bitlen (bitlen)
    ) uBuf (
        .Clk    (Clk),
        .Rst    (Rst),
        .Wr     (bufWr),
        .WrData (ParDataIn),
        .Clr    (bufClr),
        .RdData (bufData),
        .Full   (bufFull)
    );

    assign ParDataReady = !bufFull && !Rst;
`else
    assign bufFull      = 1'b0;
    assign bufData      = '0;
    assign ParDataReady = (state == IDLE) && !Rst;
`endif

    assign Busy = !Rst && ((state != IDLE) || bufFull);

    // Next-word decision: end of last bit (no gap) or end of the gap; buffered word wins.
    always_comb begin
        decide   = 1'b0;
        loadNext = bufFull || xfer;
        nextData = bufFull ? bufData : ParDataIn;
        case (state)
            SHIFT:   decide = (bitCnt == BitLast) && (gaplen == 0);
            GAP:     decide = (gapCnt == GapLast);
            default: decide = 1'b0;
        endcase
    end

    // Serializer FSM with registered serial outputs; counters reload on state entry.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= IDLE;
            shReg      <= '0;
            bitCnt     <= '0;
            gapCnt     <= '0;
            SerDataOut <= 1'b0;
            SerDataEn  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    SerDataOut <= 1'b0;
                    SerDataEn  <= 1'b0;
                    if (xfer) begin
                        shReg  <= ParDataIn;
                        bitCnt <= '0;
                        state  <= SHIFT;
                    end else begin
                        state  <= IDLE;
                    end
                end
                SHIFT: begin
                    SerDataOut <= shReg[0];
                    SerDataEn  <= 1'b1;
                    shReg      <= shReg >> 1;
                    if (bitCnt != BitLast) begin
                        bitCnt <= bitCnt + 1'b1;
                    end else if (gaplen > 0) begin
                        gapCnt <= '0;
                        state  <= GAP;
                    end else if (loadNext) begin
                        shReg  <= nextData;
                        bitCnt <= '0;
                        state  <= SHIFT;
                    end else begin
                        state  <= IDLE;
                    end
                end
                GAP: begin
                    SerDataOut <= 1'b0;
                    SerDataEn  <= 1'b0;
                    if (gapCnt != GapLast) begin
                        gapCnt <= gapCnt + 1'b1;
                    end else if (loadNext) begin
                        shReg  <= nextData;
                        bitCnt <= '0;
                        state  <= SHIFT;
                    end else begin
                        state  <= IDLE;
                    end
                end
                default: begin
                    SerDataOut <= 1'b0;
                    SerDataEn  <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_par2ser.sv
// tb_par2ser: scoreboard bench for par2ser; expected bit stream is built from accepted words.
module tb_par2ser;

    localparam int BITLEN = 8;
`ifdef PAR2SER_BUF_EN
    localparam int GAPLEN = 0;
    localparam bit BUFEN  = 1'b1;
`else
    localparam int GAPLEN = 1;
    localparam bit BUFEN  = 1'b0;
`endif
    localparam int MINGAP = BUFEN ? GAPLEN : GAPLEN + 1;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic [7:0] ParDataIn = 8'h00;
    logic       ParDataValid = 1'b0;
    logic       ParDataReady;
    logic       SerDataOut;
    logic       SerDataEn;
    logic       Busy;

    int nVec = 0;
    int nErr = 0;
    int cyc  = 0;
    bit rstPrev = 1'b1;
    bit sbq[$];
    int runLen = 0;
    int gapLen = 0;
    bit seenWord = 1'b0;

    par2ser #(
        .bitlen (BITLEN),
        .gaplen (GAPLEN)
    ) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .ParDataIn    (ParDataIn),
        .ParDataValid (ParDataValid),
        .ParDataReady (ParDataReady),
        .SerDataOut   (SerDataOut),
        .SerDataEn    (SerDataEn),
        .Busy         (Busy)
    );

    initial forever #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: every accepted word expands to BITLEN bits, LSB first; reset drops pending bits.
    always @(posedge Clk) begin
        cyc++;
        if (Rst) begin
            sbq.delete();
        end else if (ParDataValid && ParDataReady) begin
            for (int k = 0; k < BITLEN; k++) sbq.push_back(ParDataIn[k]);
        end
        rstPrev = Rst;
    end

    // Monitor: pops expected bits on SerDataEn and checks word length and inter-word gap.
    always @(negedge Clk) begin
        if (rstPrev) begin
            chk("reset_en", SerDataEn, 0);
            chk("reset_out", SerDataOut, 0);
            runLen   = 0;
            gapLen   = 0;
            seenWord = 1'b0;
        end else if (SerDataEn) begin
            if (runLen == 0 && seenWord) chk("gap_min", gapLen >= MINGAP, 1);
            runLen++;
            if (sbq.size() == 0) begin
                chk("unexpected_bit", 1, 0);
            end else begin
                chk("ser_bit", SerDataOut, sbq.pop_front());
            end
        end else begin
            chk("idle_out_zero", SerDataOut, 0);
            if (runLen > 0) begin
`ifdef PAR2SER_BUF_EN
                chk("run_len_mod", runLen % BITLEN, 0);
`else
                chk("run_len", runLen, BITLEN);
`endif
                seenWord = 1'b1;
                gapLen   = 0;
            end
            runLen = 0;
            gapLen++;
        end
    end

    task automatic sendWord(input logic [7:0] w, output int acc);
        bit ok = 1'b0;
        @(negedge Clk);
        ParDataIn    = w;
        ParDataValid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            if (ParDataReady === 1'b1) begin
                @(posedge Clk);
                #1;
                ok = 1'b1;
                break;
            end
            @(negedge Clk);
        end
        acc          = cyc;
        ParDataValid = 1'b0;
        chk("handshake", ok, 1);
    endtask

    task automatic waitIdle();
        bit ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge Clk);
            if (!Busy && !SerDataEn) begin
                ok = 1'b1;
                break;
            end
        end
        chk("idle_wait", ok, 1);
        repeat (2) @(negedge Clk);
    endtask

    initial begin
        int c1;
        int c2;

        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            chk("rst_ready", ParDataReady, 0);
            chk("rst_busy", Busy, 0);
        end
        Rst = 1'b0;
        #1;
        chk("ready_after_rst", ParDataReady, 1);

        // Single word 8'h2B: bits 1,1,0,1,0,1,0,0 come from the scoreboard.
        sendWord(8'h2B, c1);
        for (int i = 0; i <= 9 + GAPLEN; i++) begin
            @(negedge Clk);
            chk("single_en", SerDataEn, (i >= 1 && i <= 8));
            chk("single_busy", Busy, (i < 8 + GAPLEN));
`ifdef PAR2SER_BUF_EN
            chk("single_ready", ParDataReady, 1);
`else
            chk("single_ready", ParDataReady, (i >= 8 + GAPLEN));
`endif
        end
        waitIdle();

        // Source holds valid while the serializer is busy.
        sendWord(8'h5A, c1);
        sendWord(8'hC3, c2);
        chk("stall_spacing", c2 - c1, BUFEN ? 1 : BITLEN + GAPLEN + 1);
        waitIdle();

`ifdef PAR2SER_BUF_EN
        // Back-to-back through the buffer: 16 contiguous enable cycles.
        sendWord(8'hA5, c1);
        sendWord(8'h3C, c2);
        for (int j = 0; j <= 16; j++) begin
            @(negedge Clk);
            chk("b2b_en", SerDataEn, (j <= 15));
            chk("b2b_ready", ParDataReady, (j >= 7));
        end
        waitIdle();
`endif

        // Reset during bit 3 of 8'hFF (with 8'h0F buffered when the buffer exists).
        sendWord(8'hFF, c1);
`ifdef PAR2SER_BUF_EN
        sendWord(8'h0F, c2);
`endif
        while (cyc < c1 + 4) @(negedge Clk);
        chk("mid_bit3_en", SerDataEn, 1);
        Rst = 1'b1;
        @(negedge Clk);
        chk("mid_abort_en", SerDataEn, 0);
        Rst = 1'b0;
        #1;
        chk("mid_ready", ParDataReady, 1);
        sendWord(8'h01, c1);
        waitIdle();
        chk("mid_sb_empty", sbq.size(), 0);

        for (int w = 0; w < 40; w++) begin
            repeat ($urandom_range(0, 10)) @(negedge Clk);
            sendWord(8'($urandom), c1);
        end
        waitIdle();
        chk("final_sb_empty", sbq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
